// File: rtl/rram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rram_pkg
// Description : Shared encodings for the RRAM pulse sequencer: operations,
//               register offsets, FSM states and fixed hold length.
// Revision    : 1.0 - initial release
// ============================================================================
package rram_pkg;

    typedef enum logic [1:0] {
        OP_SET   = 2'b00,
        OP_RESET = 2'b01,
        OP_FORM  = 2'b10,
        OP_READ  = 2'b11
    } op_e;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_ADDR   = 5'h04;
    localparam logic [4:0] OFF_PW     = 5'h08;
    localparam logic [4:0] OFF_SETUP  = 5'h0C;
    localparam logic [4:0] OFF_STATUS = 5'h10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int HOLD_CYC = 2;

endpackage
`default_nettype wire

// File: rtl/rram_wb_regs.sv
`default_nettype none
// ============================================================================
// Module      : rram_wb_regs
// Description : Wishbone slave decode, single-cycle ack, configuration
//               registers and sticky W1C status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module rram_wb_regs
    import rram_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          PW_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_wbs_cyc,
    input  logic            i_wbs_stb,
    input  logic            i_wbs_we,
    input  logic [3:0]      i_wbs_sel,
    input  logic [31:0]     i_wbs_adr,
    input  logic [31:0]     i_wbs_dat,
    output logic            o_wbs_ack,
    output logic [31:0]     o_wbs_dat,
    input  logic            i_busy,
    input  logic            i_done_set,
    input  logic            i_sense_res,
    output logic            o_start,
    output logic [1:0]      o_start_op,
    output logic [7:0]      o_row,
    output logic [7:0]      o_col,
    output logic [PW_W-1:0] o_pw,
    output logic [7:0]      o_setup
);

    logic            ack_q;
    logic [31:0]     dat_q, dat_d;
    logic [1:0]      op_q, op_d;
    logic [7:0]      row_q, row_d, col_q, col_d, setup_q, setup_d;
    logic [PW_W-1:0] pw_q, pw_d;
    logic            done_q, done_d, err_q, err_d;

    logic       w_hit, w_acc, w_wr, w_start_req;
    logic [4:0] w_off;
    logic       w_unused;

    assign w_unused = ^{i_wbs_dat[31:16], i_wbs_sel[3:2]};

    always_comb begin
        w_off       = i_wbs_adr[4:0];
        w_hit       = (i_wbs_adr[31:5] == BASE_ADR[31:5]);
        w_acc       = i_wbs_cyc && i_wbs_stb && w_hit && !ack_q;
        w_wr        = w_acc && i_wbs_we;
        w_start_req = w_wr && (w_off == OFF_CTRL) && i_wbs_sel[0] && i_wbs_dat[0];

        op_d    = op_q;
        row_d   = row_q;
        col_d   = col_q;
        pw_d    = pw_q;
        setup_d = setup_q;
        done_d  = done_q;
        err_d   = err_q;
        dat_d   = '0;

        if (w_wr && !i_busy) begin
            case (w_off)
                OFF_CTRL:  if (i_wbs_sel[0]) op_d = i_wbs_dat[2:1];
                OFF_ADDR: begin
                    if (i_wbs_sel[0]) row_d = i_wbs_dat[7:0];
                    if (i_wbs_sel[1]) col_d = i_wbs_dat[15:8];
                end
                OFF_PW: begin
                    for (int i = 0; i < PW_W; i++) begin
                        if (i_wbs_sel[i/8]) pw_d[i] = i_wbs_dat[i];
                    end
                end
                OFF_SETUP: if (i_wbs_sel[0]) setup_d = i_wbs_dat[7:0];
                default: ;
            endcase
        end

        if (w_wr && (w_off == OFF_STATUS) && i_wbs_sel[0]) begin
            if (i_wbs_dat[1]) done_d = 1'b0;
            if (i_wbs_dat[3]) err_d  = 1'b0;
        end
        // Hardware sets are applied last so they win over a same-cycle clear.
        if (i_done_set)             done_d = 1'b1;
        if (w_start_req && i_busy)  err_d  = 1'b1;

        if (w_acc && !i_wbs_we) begin
            case (w_off)
                OFF_CTRL:   dat_d = {29'd0, op_q, 1'b0};
                OFF_ADDR:   dat_d = {16'd0, col_q, row_q};
                OFF_PW:     dat_d = 32'(pw_q);
                OFF_SETUP:  dat_d = {24'd0, setup_q};
                OFF_STATUS: dat_d = {28'd0, err_q, i_sense_res, done_q, i_busy};
                default:    dat_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            op_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            pw_q    <= '0;
            setup_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q   <= w_acc;
            dat_q   <= dat_d;
            op_q    <= op_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pw_q    <= pw_d;
            setup_q <= setup_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_wbs_ack  = ack_q;
    assign o_wbs_dat  = dat_q;
    assign o_start    = w_start_req && !i_busy;
    assign o_start_op = op_d;
    assign o_row      = row_q;
    assign o_col      = col_q;
    assign o_pw       = pw_q;
    assign o_setup    = setup_q;

endmodule
`default_nettype wire

// File: rtl/rram_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rram_pulse_sequencer
// Description : Sequences row/column select, mode and pulse for one RRAM
//               operation; samples the sense comparator and flags completion.
// Revision    : 1.0 - initial release
// ============================================================================
module rram_pulse_sequencer
    import rram_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          ROWS     = 8,
    parameter int          COLS     = 8,
    parameter int          PW_W     = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic            sense_in,
    output logic [ROWS-1:0] row_sel,
    output logic [COLS-1:0] col_sel,
    output logic [1:0]      mode,
    output logic            pulse_en,
    output logic            irq
);

    localparam int CNT_W = (PW_W > 8) ? PW_W : 8;

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [7:0]      row_q, row_d, col_q, col_d;
    logic [PW_W-1:0] pw_q, pw_d;
    logic            sense_meta_q, sense_sync_q;
    logic            sense_res_q, sense_res_d;

    logic             w_busy, w_start, w_done_set, w_selecting;
    logic [1:0]       w_start_op;
    logic [7:0]       w_row, w_col, w_setup;
    logic [PW_W-1:0]  w_pw;
    logic [CNT_W-1:0] w_setup_ld, w_pw_ld;

    rram_wb_regs #(
        .BASE_ADR (BASE_ADR),
        .PW_W     (PW_W)
    ) u_regs (
        .clk         (wb_clk_i),
        .rst         (wb_rst_i),
        .i_wbs_cyc   (wbs_cyc_i),
        .i_wbs_stb   (wbs_stb_i),
        .i_wbs_we    (wbs_we_i),
        .i_wbs_sel   (wbs_sel_i),
        .i_wbs_adr   (wbs_adr_i),
        .i_wbs_dat   (wbs_dat_i),
        .o_wbs_ack   (wbs_ack_o),
        .o_wbs_dat   (wbs_dat_o),
        .i_busy      (w_busy),
        .i_done_set  (w_done_set),
        .i_sense_res (sense_res_q),
        .o_start     (w_start),
        .o_start_op  (w_start_op),
        .o_row       (w_row),
        .o_col       (w_col),
        .o_pw        (w_pw),
        .o_setup     (w_setup)
    );

    // Counters hold N-1 so a programmed value of 0 behaves as one cycle.
    assign w_setup_ld = (w_setup == 8'd0) ? '0 : CNT_W'(w_setup - 8'd1);
    assign w_pw_ld    = (pw_q == '0) ? '0 : CNT_W'(pw_q - PW_W'(1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        row_d       = row_q;
        col_d       = col_q;
        pw_d        = pw_q;
        sense_res_d = sense_res_q;
        w_done_set  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (w_start) begin
                    state_d = ST_SETUP;
                    cnt_d   = w_setup_ld;
                    op_d    = w_start_op;
                    row_d   = w_row % 8'(ROWS);
                    col_d   = w_col % 8'(COLS);
                    pw_d    = w_pw;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = w_pw_ld;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                    if (op_q == OP_READ) sense_res_d = sense_sync_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d    = ST_DONE;
                    w_done_set = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            row_q        <= '0;
            col_q        <= '0;
            pw_q         <= '0;
            sense_meta_q <= 1'b0;
            sense_sync_q <= 1'b0;
            sense_res_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            row_q        <= row_d;
            col_q        <= col_d;
            pw_q         <= pw_d;
            sense_meta_q <= sense_in;
            sense_sync_q <= sense_meta_q;
            sense_res_q  <= sense_res_d;
        end
    end

    assign w_busy      = (state_q == ST_SETUP) || (state_q == ST_PULSE) || (state_q == ST_HOLD);
    assign w_selecting = w_busy;
    assign row_sel     = w_selecting ? ({{(ROWS-1){1'b0}}, 1'b1} << row_q) : '0;
    assign col_sel     = w_selecting ? ({{(COLS-1){1'b0}}, 1'b1} << col_q) : '0;
    assign mode        = (state_q == ST_IDLE) ? 2'b00 : op_q;
    assign pulse_en    = (state_q == ST_PULSE);
    assign irq         = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_rram_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rram_pulse_sequencer
// Description : Directed scoreboard bench for the RRAM pulse sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rram_pulse_sequencer;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        sense_in = 1'b0;
    logic [7:0]  row_sel, col_sel;
    logic [1:0]  mode;
    logic        pulse_en, irq;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] setup;
        logic [15:0] pw;
        logic [7:0]  row;
        logic [7:0]  col;
        logic [1:0]  mode;
    } op_exp_t;

    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    op_exp_t     op_exp_q[$];

    rram_pulse_sequencer #(
        .BASE_ADR (BASE),
        .ROWS     (8),
        .COLS     (8),
        .PW_W     (16)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .sense_in  (sense_in),
        .row_sel   (row_sel),
        .col_sel   (col_sel),
        .mode      (mode),
        .pulse_en  (pulse_en),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Read-data monitor: pops an expected value on every read acknowledge.
    logic prev_ack = 1'b0;
    always @(posedge clk) begin
        #2;
        if (ack) begin
            chk("ack_one_cycle", {31'd0, prev_ack}, 32'd0);
            if (!we) begin
                if (rd_exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read_ack actual=0x%08h required=none", rdat);
                end else begin
                    chk(rd_name_q.pop_front(), rdat, rd_exp_q.pop_front());
                end
            end
        end
        prev_ack = ack;
    end

    // Operation monitor: measures phase lengths and selects, checks on irq.
    int        n_setup = 0, n_pulse = 0, n_hold = 0;
    logic [7:0] cap_row = '0, cap_col = '0;
    logic [1:0] cap_mode = '0;
    always @(posedge clk) begin
        op_exp_t e;
        #2;
        if (rst) begin
            n_setup = 0; n_pulse = 0; n_hold = 0;
        end else if (irq) begin
            if (op_exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_irq actual=1 required=0");
            end else begin
                e = op_exp_q.pop_front();
                chk("setup_cycles", 32'(n_setup), 32'(e.setup));
                chk("pulse_cycles", 32'(n_pulse), 32'(e.pw));
                chk("hold_cycles", 32'(n_hold), 32'd2);
                chk("row_sel_in_pulse", 32'(cap_row), 32'(e.row));
                chk("col_sel_in_pulse", 32'(cap_col), 32'(e.col));
                chk("mode_in_pulse", 32'(cap_mode), 32'(e.mode));
                chk("mode_at_done", 32'(mode), 32'(e.mode));
                chk("outputs_clear_at_done", {15'd0, row_sel, col_sel, pulse_en}, 32'd0);
            end
            n_setup = 0; n_pulse = 0; n_hold = 0;
        end else if (row_sel != 8'd0) begin
            if (pulse_en) begin
                n_pulse++;
                cap_row  = row_sel;
                cap_col  = col_sel;
                cap_mode = mode;
            end else if (n_pulse == 0) begin
                n_setup++;
            end else begin
                n_hold++;
            end
        end
    end

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic got_ack);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        got_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                got_ack = 1'b1;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] off, input logic [31:0] d, input logic [3:0] s);
        logic ok;
        wb_xfer(1'b1, BASE + 32'(off), d, s, ok);
        chk("write_ack", {31'd0, ok}, 32'd1);
    endtask

    task automatic wb_read(input logic [7:0] off, input logic [31:0] exp, input string name);
        logic ok;
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        wb_xfer(1'b0, BASE + 32'(off), 32'd0, 4'hF, ok);
        chk("read_ack", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_irq(output int n);
        logic got;
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #2;
            n = n + 1;
            if (irq) begin
                got = 1'b1;
                break;
            end
        end
        chk("irq_seen", {31'd0, got}, 32'd1);
    endtask

    initial begin
        int   n;
        logic got;
        int   acks;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {11'd0, ack, row_sel, col_sel, mode, pulse_en, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        wb_read(8'h00, 32'h0, "reset_ctrl");
        wb_read(8'h04, 32'h0, "reset_addr");
        wb_read(8'h08, 32'h0, "reset_pw");
        wb_read(8'h0C, 32'h0, "reset_setup");
        wb_read(8'h10, 32'h0, "reset_status");

        // SET on row 2 / col 3, setup 2, pulse 4
        wb_write(5'h04, 32'h0000_0302, 4'hF);
        wb_write(5'h08, 32'd4, 4'hF);
        wb_write(5'h0C, 32'd2, 4'hF);
        op_exp_q.push_back('{setup: 16'd2, pw: 16'd4, row: 8'h04, col: 8'h08, mode: 2'b00});
        wb_write(5'h00, 32'h1, 4'hF);
        wait_irq(n);
        chk("latency_set", 32'(n + 1), 32'd9);
        wb_read(8'h10, 32'h2, "status_after_set");

        // READ with sense high, then low
        sense_in = 1'b1;
        wb_write(5'h08, 32'd3, 4'hF);
        op_exp_q.push_back('{setup: 16'd2, pw: 16'd3, row: 8'h04, col: 8'h08, mode: 2'b11});
        wb_write(5'h00, 32'h7, 4'hF);
        wait_irq(n);
        wb_read(8'h10, 32'h6, "status_read_sense1");
        sense_in = 1'b0;
        op_exp_q.push_back('{setup: 16'd2, pw: 16'd3, row: 8'h04, col: 8'h08, mode: 2'b11});
        wb_write(5'h00, 32'h7, 4'hF);
        wait_irq(n);
        wb_read(8'h10, 32'h2, "status_read_sense0");
        wb_read(8'h00, 32'h6, "ctrl_op_readback");

        // Writes while busy: start sets err, PW change ignored
        wb_write(5'h08, 32'd4, 4'hF);
        op_exp_q.push_back('{setup: 16'd2, pw: 16'd4, row: 8'h04, col: 8'h08, mode: 2'b00});
        wb_write(5'h00, 32'h1, 4'hF);
        wb_write(5'h00, 32'h1, 4'hF);
        wb_write(5'h08, 32'd9, 4'hF);
        wait_irq(n);
        wb_read(8'h10, 32'hA, "status_err_done");
        wb_read(8'h08, 32'd4, "pw_unchanged");
        wb_write(5'h10, 32'hA, 4'hF);
        wb_read(8'h10, 32'h0, "status_w1c");

        // Index wrap, byte lanes, zero pulse/setup as one cycle (FORM)
        wb_write(5'h04, 32'h0000_0B0A, 4'h3);
        wb_read(8'h04, 32'h0000_0B0A, "addr_raw");
        wb_write(5'h04, 32'hFFFF_0500, 4'b0010);
        wb_read(8'h04, 32'h0000_050A, "addr_byte_lane");
        wb_write(5'h08, 32'd0, 4'hF);
        wb_write(5'h0C, 32'd0, 4'hF);
        op_exp_q.push_back('{setup: 16'd1, pw: 16'd1, row: 8'h04, col: 8'h20, mode: 2'b10});
        wb_write(5'h00, 32'h5, 4'hF);
        wait_irq(n);
        chk("latency_min", 32'(n + 1), 32'd5);
        wb_read(8'h10, 32'h2, "status_after_form");

        // Asynchronous reset during the pulse
        wb_write(5'h08, 32'd10, 4'hF);
        wb_write(5'h0C, 32'd2, 4'hF);
        wb_write(5'h00, 32'h3, 4'hF);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (pulse_en) begin
                got = 1'b1;
                break;
            end
        end
        chk("pulse_before_reset", {31'd0, got}, 32'd1);
        #1 rst = 1'b1;
        #1 chk("async_reset_outputs", {13'd0, row_sel, col_sel, mode, pulse_en, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        wb_read(8'h10, 32'h0, "status_after_reset");
        wb_read(8'h08, 32'h0, "pw_after_reset");

        // Unmapped offsets inside the window, then outside the window
        wb_read(8'h14, 32'h0, "unmapped_read");
        wb_write(5'h18, 32'hFFFF_FFFF, 4'hF);
        wb_read(8'h18, 32'h0, "unmapped_after_write");
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h40; sel = 4'hF;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (ack) acks++;
        end
        chk("out_of_range_no_ack", 32'(acks), 32'd0);
        chk("out_of_range_data", rdat, 32'd0);
        cyc = 1'b0; stb = 1'b0;

        repeat (5) @(posedge clk);
        chk("read_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        chk("op_queue_drained", 32'(op_exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
